spram_stream_ctrl: RTL and testbench
====================================

// Module: spram_stream_ctrl
// PURPOSE
// - Sequencing front-end for the spram_wrapper single-port on-chip buffer.
// - Writes a valid/ready input stream into consecutive words, and reads consecutive words back out as a valid/ready stream.
// - Hides the SPRAM read latency (N_DELAY) behind a credit-controlled return FIFO, so a stalled consumer never loses data.
// PARAMETERS
// - DW       32    data bits per word
// - AW       13    address bits
// - DEPTH    6240  words in SPRAM; addresses wrap DEPTH-1 -> 0
// - N_DELAY  1     cycles from ram_cs (read) to valid ram_rdata
// - LW       13    burst-length bits
// PORTS
// - clk        in   1   clock, rising edge
// - rst        in   1   reset, asynchronous, active-high
// - start_wr   in   1   pulse: begin write burst at base_addr, len words
// - start_rd   in   1   pulse: begin read burst at base_addr, len words
// - base_addr  in   AW  first word address (< DEPTH)
// - len        in   LW  burst length in words
// - busy       out  1   burst in progress
// - done       out  1   one-cycle pulse when burst fully complete
// - s_valid    in   1   write-stream data valid
// - s_ready    out  1   write-stream accept
// - s_data     in   DW  write-stream data
// - m_valid    out  1   read-stream data valid
// - m_ready    in   1   read-stream accept
// - m_data     out  DW  read-stream data
// - ram_cs     out  1   to spram_wrapper cs
// - ram_we     out  1   to spram_wrapper we
// - ram_addr   out  AW  to spram_wrapper addr
// - ram_wdata  out  DW  to spram_wrapper wdata
// - ram_rdata  in   DW  from spram_wrapper rdata
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; FIFO emptied; in-flight reads discarded.
//   - busy, done, s_ready, m_valid, ram_cs, ram_we = 0.
//   - ram_addr, ram_wdata, m_data = 0.
// - FSM states: IDLE, WRITE, READ, DRAIN.
//   - IDLE: start_wr -> WRITE; start_rd -> READ; both asserted together -> WRITE wins, read is ignored.
//     - Latch base_addr and len on the start cycle.
//     - len=0 -> stay IDLE, pulse done next cycle, no RAM access.
//   - Starts while busy=1 are ignored.
//   - WRITE: s_ready=1.
//     - Each s_valid&s_ready drives ram_cs=ram_we=1, ram_addr=addr, ram_wdata=s_data combinationally (same cycle).
//     - addr increments, wrapping at DEPTH-1 -> 0; remaining decrements.
//     - Last beat -> IDLE next cycle with done=1. s_ready=0 in IDLE.
//   - READ: issue read (ram_cs=1, ram_we=0) when remaining>0 and (fifo_count + inflight) < FIFO_DEPTH.
//     - After the last issue -> DRAIN.
//   - DRAIN: wait until inflight=0 and FIFO empty -> IDLE, done=1 that cycle.
//     - done fires in the cycle after the last m_valid&m_ready.
// - Read return: an N_DELAY-deep shift register of valid bits tracks inflight reads.
//   - ram_rdata is pushed into the FIFO exactly N_DELAY cycles after its ram_cs cycle.
//   - m_valid/m_data come from the FIFO head (registered), first visible the cycle after the push.
//   - With m_ready held high, throughput is one word/cycle.
//   - Start-to-first-m_valid latency is N_DELAY+2 cycles.
// - FIFO_DEPTH = N_DELAY+2 (localparam). The credit rule guarantees the FIFO never overflows.
//   - A simultaneous push and pop at full count is legal.
// - busy=1 in WRITE/READ/DRAIN; busy drops in the same cycle done pulses.
// - Address wrap applies in both directions of traffic: base_addr=DEPTH-1, len=2 -> addresses DEPTH-1, 0.
// - ram_we is never asserted outside WRITE. ram_cs is never asserted in IDLE or DRAIN.
// STRUCTURE
// - Package spram_ctrl_pkg: FSM state enum; FIFO_DEPTH derivation; addr-wrap function next_addr(a) = (a==DEPTH-1)?0:a+1.
// - Sub-module spram_rd_fifo (DW, FIFO_DEPTH):
//   - synchronous FIFO with registered head and push/pop/count.
//   - async active-high reset.
// - Top module: FSM, address/length counters, inflight shift register, credit compare.
// TESTING
// - Write 16 words 32'h00000000..32'hffffffff (step 32'h11111111) from base 0, s_valid held high
//   -> 16 consecutive ram_cs&ram_we cycles at addr 0..15, done 1 cycle after the last beat.
// - Read 16 words from base 0 with m_ready=1 (N_DELAY=1)
//   -> m_data 0x00000000..0xffffffff on 16 consecutive cycles, first m_valid 3 cycles after start_rd.
// - Read 16 words with m_ready toggled 1-cycle-on/3-off
//   -> no word lost or duplicated, fifo_count never exceeds 3, ram_cs stalls while credits are exhausted.
// - Write then read len=3 at base 6239
//   -> ram_addr sequence 6239, 0, 1; read-back data matches the written data.
// - start_wr and start_rd in the same cycle
//   -> write burst runs; start_rd during busy is ignored; len=0 -> done next cycle, no ram_cs.
// - Assert rst mid-READ with 2 words in flight
//   -> all outputs 0 immediately; after release a new read of 4 words returns exactly 4 correct words.

Source files
------------

// File: rtl/spram_ctrl_pkg.sv
// Shared types, sizes and helpers for the SPRAM stream controller.
package spram_ctrl_pkg;
  localparam int DW         = 32;
  localparam int AW         = 13;
  localparam int DEPTH      = 6240;
  localparam int N_DELAY    = 1;
  localparam int LW         = 13;
  localparam int FIFO_DEPTH = N_DELAY + 2;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    if (a == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return a + AW'(1);
    end
  endfunction
endpackage

// File: rtl/spram_rd_fifo.sv
// Read-return FIFO: small circular buffer feeding a registered head word.
module spram_rd_fifo #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 3,
  localparam int CW        = $clog2(FIFO_DEPTH + 1),
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          head_valid,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] buf_cnt_r;
  logic          head_valid_r;
  logic [DW-1:0] head_data_r;
  logic          pop_s, head_free_s, load_buf_s, bypass_s, store_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Head refill priority: buffered words first, otherwise bypass the incoming push.
  always_comb begin
    pop_s       = pop & head_valid_r;
    head_free_s = ~head_valid_r | pop_s;
    load_buf_s  = head_free_s & (buf_cnt_r != '0);
    bypass_s    = head_free_s & (buf_cnt_r == '0) & push;
    store_s     = push & ~bypass_s;
  end

  // Head register, pointers and buffer occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      buf_cnt_r    <= '0;
      head_valid_r <= 1'b0;
      head_data_r  <= '0;
    end else begin
      if (load_buf_s) begin
        head_valid_r <= 1'b1;
        head_data_r  <= mem_r[rd_ptr_r];
        rd_ptr_r     <= ptr_inc(rd_ptr_r);
      end else if (bypass_s) begin
        head_valid_r <= 1'b1;
        head_data_r  <= push_data;
      end else if (head_free_s) begin
        head_valid_r <= 1'b0;
      end
      if (store_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      case ({store_s, load_buf_s})
        2'b10:   buf_cnt_r <= buf_cnt_r + CW'(1);
        2'b01:   buf_cnt_r <= buf_cnt_r - CW'(1);
        default: buf_cnt_r <= buf_cnt_r;
      endcase
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;
  assign count      = buf_cnt_r + {{(CW-1){1'b0}}, head_valid_r};
endmodule

// File: rtl/spram_stream_ctrl.sv
// Burst sequencer between valid/ready streams and a single-port SPRAM,
// with credit-limited reads so the return FIFO can never overflow.
module spram_stream_ctrl
  import spram_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start_wr,
  input  logic          start_rd,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  state_t             state_r, state_s;
  logic [AW-1:0]      addr_r;
  logic [LW-1:0]      rem_r;
  logic               done_r;
  logic [N_DELAY-1:0] sr_r;
  logic [CW-1:0]      inflight_s, fifo_cnt_s;
  logic               credit_ok_s, wr_fire_s, rd_issue_s, pop_s, drain_done_s, start_s;

  // Credit and drain bookkeeping.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      inflight_s = inflight_s + {{(CW-1){1'b0}}, sr_r[i]};
    end
    pop_s        = m_valid & m_ready;
    credit_ok_s  = ({1'b0, fifo_cnt_s} + {1'b0, inflight_s}) < (CW+1)'(FIFO_DEPTH);
    // Leave DRAIN on the edge that empties everything, so done lands right after the last pop.
    drain_done_s = (inflight_s == '0) &&
                   ((fifo_cnt_s == '0) || ((fifo_cnt_s == CW'(1)) && pop_s));
    start_s      = (state_r == ST_IDLE) && (start_wr || start_rd);
  end

  // Next-state and RAM-side outputs.
  always_comb begin
    state_s    = state_r;
    s_ready    = 1'b0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    wr_fire_s  = 1'b0;
    rd_issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_wr && (len != '0)) begin
          state_s = ST_WRITE;
        end else if (start_rd && !start_wr && (len != '0)) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_fire_s = 1'b1;
          ram_cs    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = addr_r;
          ram_wdata = s_data;
          state_s   = (rem_r == LW'(1)) ? ST_IDLE : ST_WRITE;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (credit_ok_s) begin
          rd_issue_s = 1'b1;
          ram_cs     = 1'b1;
          ram_addr   = addr_r;
          state_s    = (rem_r == LW'(1)) ? ST_DRAIN : ST_READ;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        state_s = drain_done_s ? ST_IDLE : ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, burst counters, done pulse and in-flight read tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      rem_r   <= '0;
      done_r  <= 1'b0;
      sr_r    <= '0;
    end else begin
      state_r <= state_s;
      done_r  <= (start_s && (len == '0)) ||
                 ((state_r != ST_IDLE) && (state_s == ST_IDLE));
      if (start_s) begin
        addr_r <= base_addr;
        rem_r  <= len;
      end else if (wr_fire_s || rd_issue_s) begin
        addr_r <= next_addr(addr_r);
        rem_r  <= rem_r - LW'(1);
      end
      sr_r[0] <= rd_issue_s;
      for (int i = 1; i < N_DELAY; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

  spram_rd_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (sr_r[N_DELAY-1]),
    .push_data  (ram_rdata),
    .pop        (m_ready),
    .head_valid (m_valid),
    .head_data  (m_data),
    .count      (fifo_cnt_s)
  );

  assign busy = (state_r != ST_IDLE);
  assign done = done_r;
endmodule

// File: tb/tb_spram_stream_ctrl.sv
// Directed, table-driven bench for spram_stream_ctrl with a behavioural 1-cycle SPRAM.
module tb_spram_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_wr = 1'b0, start_rd = 1'b0;
  logic [12:0] base_addr = '0;
  logic [12:0] len = '0;
  logic        busy, done, s_ready, m_valid, ram_cs, ram_we;
  logic        s_valid = 1'b0, m_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic [31:0] m_data, ram_wdata, ram_rdata;
  logic [12:0] ram_addr;

  logic [31:0] mem [6240];
  int n_checks = 0;
  int n_pass = 0;

  typedef struct { logic [12:0] addr; logic [31:0] data; } vec_t;
  vec_t tbl [16];

  spram_stream_ctrl dut (
    .clk(clk), .rst(rst), .start_wr(start_wr), .start_rd(start_rd),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [12:0] base, input int n);
    int cyc, beats, first_b, last_b;
    bit seen;
    start_wr = 1'b1; base_addr = base; len = 13'(n);
    s_valid = 1'b1; s_data = tbl[0].data;
    @(negedge clk);
    chk("wr_start_idle_no_cs", {63'd0, ram_cs}, 64'd0);
    tick();
    start_wr = 1'b0;
    cyc = 1; beats = 0; first_b = -1; last_b = -1; seen = 1'b0;
    while (!seen && cyc < 100) begin
      s_data = tbl[(beats < 16) ? beats : 15].data;
      @(negedge clk);
      if (ram_cs) begin
        chk("wr_we", {63'd0, ram_we}, 64'd1);
        chk("wr_addr", {51'd0, ram_addr}, {51'd0, tbl[beats].addr});
        chk("wr_data", {32'd0, ram_wdata}, {32'd0, tbl[beats].data});
        if (first_b < 0) first_b = cyc;
        last_b = cyc;
        beats++;
      end
      if (done) begin
        seen = 1'b1;
        chk("wr_done_after_last_beat", 64'(cyc), 64'(last_b + 1));
        chk("wr_busy_low_at_done", {63'd0, busy}, 64'd0);
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    chk("wr_done_seen", {63'd0, seen}, 64'd1);
    chk("wr_beats", 64'(beats), 64'(n));
    chk("wr_consecutive", 64'(last_b - first_b), 64'(n - 1));
  endtask

  // mode 0: m_ready held high; mode 1: m_ready 1 cycle on, 3 off.
  task automatic do_read(input logic [12:0] base, input int n, input int mode, input int exp_lat);
    int cyc, issues, got, first_v, last_pop, maxcnt;
    bit seen, stall;
    start_rd = 1'b1; base_addr = base; len = 13'(n); m_ready = (mode == 0);
    @(negedge clk);
    tick();
    start_rd = 1'b0;
    cyc = 1; issues = 0; got = 0; first_v = -1; last_pop = -1; maxcnt = 0;
    seen = 1'b0; stall = 1'b0;
    while (!seen && cyc < 300) begin
      m_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0);
      @(negedge clk);
      if (ram_cs) begin
        chk("rd_we_low", {63'd0, ram_we}, 64'd0);
        if (issues < n) chk("rd_addr", {51'd0, ram_addr}, {51'd0, tbl[issues].addr});
        issues++;
      end else if (busy && issues < n) begin
        stall = 1'b1;
      end
      if (int'(dut.fifo_cnt_s) > maxcnt) maxcnt = int'(dut.fifo_cnt_s);
      if (m_valid && m_ready) begin
        if (got < n) chk("rd_data", {32'd0, m_data}, {32'd0, tbl[got].data});
        if (first_v < 0) first_v = cyc;
        last_pop = cyc;
        got++;
      end
      if (done) begin
        seen = 1'b1;
        chk("rd_done_after_last_pop", 64'(cyc), 64'(last_pop + 1));
        chk("rd_busy_low_at_done", {63'd0, busy}, 64'd0);
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    chk("rd_done_seen", {63'd0, seen}, 64'd1);
    chk("rd_words", 64'(got), 64'(n));
    chk("rd_issues", 64'(issues), 64'(n));
    if (exp_lat > 0) chk("rd_first_latency", 64'(first_v), 64'(exp_lat));
    if (mode == 1) begin
      chk("rd_credit_stall", {63'd0, stall}, 64'd1);
      chk("rd_fifo_max_le3", {63'd0, (maxcnt <= 3)}, 64'd1);
    end
    @(negedge clk);
    chk("rd_done_one_cycle", {63'd0, done}, 64'd0);
    tick();
  endtask

  initial begin
    bit quiet;
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 13'(i);
      tbl[i].data = 32'(i) * 32'h11111111;
    end
    tick(); tick();
    @(negedge clk);
    chk("reset_ctrl", {58'd0, busy, done, s_ready, m_valid, ram_cs, ram_we}, 64'd0);
    chk("reset_addr_wdata", {19'd0, ram_addr, ram_wdata}, 64'd0);
    chk("reset_mdata", {32'd0, m_data}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    do_write(13'd0, 16);
    do_read(13'd0, 16, 0, 3);
    do_read(13'd0, 16, 1, 0);

    // Address wrap at the top of the array.
    tbl[0].addr = 13'd6239; tbl[0].data = 32'hA5A5_0001;
    tbl[1].addr = 13'd0;    tbl[1].data = 32'hA5A5_0002;
    tbl[2].addr = 13'd1;    tbl[2].data = 32'hA5A5_0003;
    do_write(13'd6239, 3);
    do_read(13'd6239, 3, 0, 3);

    // Simultaneous starts: write wins, read during busy ignored.
    start_wr = 1'b1; start_rd = 1'b1; base_addr = 13'd100; len = 13'd2;
    tick();
    start_wr = 1'b0; start_rd = 1'b0;
    @(negedge clk);
    chk("both_start_s_ready", {62'd0, s_ready, busy}, 64'd3);
    tick();
    start_rd = 1'b1; base_addr = 13'd200; len = 13'd5;
    s_valid = 1'b1; s_data = 32'hDEAD0001;
    @(negedge clk);
    chk("both_beat0", {50'd0, ram_cs, ram_we, ram_addr}, {50'd0, 2'b11, 13'd100});
    tick();
    start_rd = 1'b0; s_data = 32'hDEAD0002;
    @(negedge clk);
    chk("both_beat1", {50'd0, ram_cs, ram_we, ram_addr}, {50'd0, 2'b11, 13'd101});
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    chk("both_done", {62'd0, done, busy}, 64'd2);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      if (ram_cs || m_valid || busy) quiet = 1'b0;
    end
    chk("ignored_read_quiet", {63'd0, quiet}, 64'd1);
    tick();

    // Zero-length burst.
    start_wr = 1'b1; base_addr = 13'd5; len = 13'd0;
    @(negedge clk);
    chk("len0_no_cs", {63'd0, ram_cs}, 64'd0);
    tick();
    start_wr = 1'b0;
    @(negedge clk);
    chk("len0_done", {61'd0, done, busy, ram_cs}, 64'd4);
    tick();
    @(negedge clk);
    chk("len0_done_pulse", {63'd0, done}, 64'd0);
    tick();

    // Reset in the middle of a read burst.
    for (int i = 0; i < 16; i++) begin
      tbl[i].addr = 13'(i);
      tbl[i].data = 32'(i) * 32'h11111111;
    end
    start_rd = 1'b1; base_addr = 13'd8; len = 13'd8; m_ready = 1'b0;
    tick();
    start_rd = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {58'd0, busy, done, s_ready, m_valid, ram_cs, ram_we}, 64'd0);
    chk("midrst_addr_wdata", {19'd0, ram_addr, ram_wdata}, 64'd0);
    chk("midrst_mdata", {32'd0, m_data}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tbl[i].addr = 13'(i + 4);
      tbl[i].data = 32'(i + 4) * 32'h11111111;
    end
    do_read(13'd4, 4, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
